csi_rx_capture_ctrl: RTL

Frame-capture sequencer placed after the CSI-2 packet handler, in the word_clk domain. It arms on host request and waits for a clean frame start. It then gates the 32-bit payload stream into a downstream frame writer with start-of-frame and start-of-line markers, and checks line lengths and line count. It reports completion or errors, in either single-shot or continuous mode.

---
 rtl/csi_rx_capture_ctrl_if.sv | 25 ++
 rtl/csi_rx_capture_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_capture_ctrl_if.sv
// Payload stream from the CSI-2 packet handler and the gated word stream
// towards the frame writer.
interface csi_rx_capture_ctrl_if;
    logic [31:0] payload_data;
    logic        payload_enable;
    logic        payload_frame;
    logic        in_frame;

    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_sof;
    logic        wr_sol;

    // Packet-handler / writer side.
    modport master (
        output payload_data, payload_enable, payload_frame, in_frame,
        input  wr_data, wr_en, wr_sof, wr_sol
    );

    // Capture controller side.
    modport slave (
        input  payload_data, payload_enable, payload_frame, in_frame,
        output wr_data, wr_en, wr_sof, wr_sol
    );
endinterface

// File: rtl/csi_rx_capture_ctrl.sv
// Frame-capture sequencer: arms on host request, waits for a clean frame start,
// gates payload words to the frame writer and checks line length / line count.
module csi_rx_capture_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clock,
    input  logic                 areset_n,
    input  logic                 arm,
    input  logic                 continuous,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     exp_words,
    input  logic [CNT_W-1:0]     exp_lines,
    csi_rx_capture_ctrl_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len,
    output logic                 err_lines,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     line_count,
    output logic [CNT_W-1:0]     frame_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_e            state_q, state_d;
    logic              cont_q, cont_d;
    logic              in_frame_q;
    logic              payload_frame_q;
    logic              pending_sof_q, pending_sof_d;
    logic              pending_sol_q, pending_sol_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]  line_count_q, line_count_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;
    logic              err_len_q, err_len_d;
    logic              err_lines_q, err_lines_d;
    logic              err_timeout_q, err_timeout_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_sof_q, wr_sof_d;
    logic              wr_sol_q, wr_sol_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              frame_start;
    logic              frame_end;
    logic              line_start;
    logic              line_end;
    logic [CNT_W-1:0]  word_eff;

    assign frame_start = bus.in_frame & ~in_frame_q;
    assign frame_end   = ~bus.in_frame & in_frame_q;
    assign line_start  = bus.payload_frame & ~payload_frame_q;
    assign line_end    = ~bus.payload_frame & payload_frame_q;

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_d       = state_q;
        cont_d        = cont_q;
        pending_sof_d = pending_sof_q;
        pending_sol_d = pending_sol_q;
        word_cnt_d    = word_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        line_count_d  = line_count_q;
        frame_count_d = frame_count_q;
        err_len_d     = err_len_q;
        err_lines_d   = err_lines_q;
        err_timeout_d = err_timeout_q;
        wr_data_d     = wr_data_q;
        wr_en_d       = 1'b0;
        wr_sof_d      = 1'b0;
        wr_sol_d      = 1'b0;
        done_d        = 1'b0;
        word_eff      = word_cnt_q;

        // Abort outranks everything; counters and error flags simply hold.
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        cont_d        = continuous;
                        err_len_d     = 1'b0;
                        err_lines_d   = 1'b0;
                        err_timeout_d = 1'b0;
                        frame_count_d = '0;
                        line_count_d  = '0;
                        state_d       = WAIT_FS;
                    end
                end

                WAIT_FS: begin
                    if (frame_start) begin
                        pending_sof_d = 1'b1;
                        pending_sol_d = 1'b0;
                        word_cnt_d    = '0;
                        line_count_d  = '0;
                        tmo_cnt_d     = '0;
                        state_d       = CAPTURE;
                    end
                end

                CAPTURE: begin
                    // A word in the line-end cycle still belongs to the ending line.
                    word_eff = bus.payload_enable ? sat_inc(word_cnt_q) : word_cnt_q;

                    if (line_start) begin
                        word_cnt_d = bus.payload_enable ? CNT_ONE : '0;
                    end else begin
                        word_cnt_d = word_eff;
                    end

                    if (bus.payload_enable) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = bus.payload_data;
                        wr_sof_d  = pending_sof_q;
                        wr_sol_d  = pending_sol_q | line_start;
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                    pending_sof_d = pending_sof_q & ~bus.payload_enable;
                    pending_sol_d = (pending_sol_q | line_start) & ~bus.payload_enable;

                    if (line_end) begin
                        line_count_d = sat_inc(line_count_q);
                        if (exp_words != '0 && word_eff != exp_words) begin
                            err_len_d = 1'b1;
                        end
                    end

                    if (!bus.payload_enable && tmo_cnt_q == TMO_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = DONE;
                    end else if (frame_end) begin
                        state_d = DONE;
                    end
                end

                DONE: begin
                    done_d        = 1'b1;
                    frame_count_d = sat_inc(frame_count_q);
                    if (exp_lines != '0 && line_count_q != exp_lines) begin
                        err_lines_d = 1'b1;
                    end
                    state_d = cont_q ? WAIT_FS : IDLE;
                end

                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q         <= IDLE;
            cont_q          <= 1'b0;
            in_frame_q      <= 1'b0;
            payload_frame_q <= 1'b0;
            pending_sof_q   <= 1'b0;
            pending_sol_q   <= 1'b0;
            word_cnt_q      <= '0;
            tmo_cnt_q       <= '0;
            line_count_q    <= '0;
            frame_count_q   <= '0;
            err_len_q       <= 1'b0;
            err_lines_q     <= 1'b0;
            err_timeout_q   <= 1'b0;
            wr_data_q       <= '0;
            wr_en_q         <= 1'b0;
            wr_sof_q        <= 1'b0;
            wr_sol_q        <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cont_q          <= cont_d;
            in_frame_q      <= bus.in_frame;
            payload_frame_q <= bus.payload_frame;
            pending_sof_q   <= pending_sof_d;
            pending_sol_q   <= pending_sol_d;
            word_cnt_q      <= word_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            line_count_q    <= line_count_d;
            frame_count_q   <= frame_count_d;
            err_len_q       <= err_len_d;
            err_lines_q     <= err_lines_d;
            err_timeout_q   <= err_timeout_d;
            wr_data_q       <= wr_data_d;
            wr_en_q         <= wr_en_d;
            wr_sof_q        <= wr_sof_d;
            wr_sol_q        <= wr_sol_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.wr_data  = wr_data_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_sof   = wr_sof_q;
    assign bus.wr_sol   = wr_sol_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_len      = err_len_q;
    assign err_lines    = err_lines_q;
    assign err_timeout  = err_timeout_q;
    assign line_count   = line_count_q;
    assign frame_count  = frame_count_q;

endmodule
